// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures one record per retired instruction, tags it
// with a retire sequence number and streams it out through a valid/ready FIFO.
module retire_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SEQ_W  = 16,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     flush,
    input  logic                     clear_ovf,
    input  logic                     retire_valid,
    input  logic [31:0]              retire_pc,
    input  logic [31:0]              retire_instr,
    input  logic                     rd_we,
    input  logic [4:0]               rd_addr,
    input  logic [31:0]              rd_wdata,
    input  logic                     mem_we,
    input  logic [1:0]               mem_size,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_rdata,
    output logic [1:0]               out_write_op,
    output logic [31:0]              out_wdata,
    output logic [31:0]              out_waddr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic [31:0]      rdata;
        logic [1:0]       write_op;
        logic [31:0]      wdata;
        logic [31:0]      waddr;
    } trace_rec_t;

    trace_rec_t       mem [DEPTH];
    trace_rec_t       rec_c;
    trace_rec_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SEQ_W-1:0] seq;

    logic push_c;
    logic pop_c;
    logic full_c;
    logic accept_c;
    logic drop_c;

    // Handshake decode; flush overrides both push and pop.
    always_comb begin
        push_c   = retire_valid & trace_en & ~flush;
        pop_c    = out_valid & out_ready & ~flush;
        full_c   = (count == CNT_W'(DEPTH));
        accept_c = push_c & (~full_c | pop_c);
        drop_c   = push_c & full_c & ~pop_c;
    end

    // Record formation: suppress x0 writes, decode store size, mask store data.
    always_comb begin
        rec_c       = '0;
        rec_c.seq   = seq;
        rec_c.pc    = retire_pc;
        rec_c.instr = retire_instr;
        if (rd_we && (rd_addr != 5'd0)) begin
            rec_c.rd    = rd_addr;
            rec_c.rdata = rd_wdata;
        end
        if (mem_we && (mem_size != 2'd3)) begin
            rec_c.write_op = 2'(mem_size + 2'd1);
            rec_c.waddr    = mem_addr;
            case (mem_size)
                2'd0:    rec_c.wdata = {24'b0, mem_wdata[7:0]};
                2'd1:    rec_c.wdata = {16'b0, mem_wdata[15:0]};
                default: rec_c.wdata = mem_wdata;
            endcase
        end
    end

    // FIFO storage; contents survive flush, only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (accept_c) begin
            mem[wr_ptr] <= rec_c;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Retire sequence counter advances on every retire, captured or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq <= '0;
        end else if (retire_valid) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    // Overflow tracking; a drop in the same cycle as clear_ovf takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_ovf) begin
            ovf      <= drop_c;
            drop_cnt <= DROP_W'(drop_c);
        end else if (drop_c) begin
            ovf <= 1'b1;
            if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    // Head entry drives the output stream.
    always_comb begin
        head         = mem[rd_ptr];
        out_valid    = (count != '0);
        out_seq      = head.seq;
        out_pc       = head.pc;
        out_instr    = head.instr;
        out_rd       = head.rd;
        out_rdata    = head.rdata;
        out_write_op = head.write_op;
        out_wdata    = head.wdata;
        out_waddr    = head.waddr;
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: queue-based reference FIFO checked every cycle,
// plus directed scenarios and a randomized phase.
module tb_retire_trace_buffer;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] ADDI_X5 = 32'h0110_0293;

    logic        clk;
    logic        rst;
    logic        trace_en;
    logic        flush;
    logic        clear_ovf;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_seq;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rd;
    logic [31:0] out_rdata;
    logic [1:0]  out_write_op;
    logic [31:0] out_wdata;
    logic [31:0] out_waddr;
    logic [4:0]  count;
    logic        ovf;
    logic [7:0]  drop_cnt;

    retire_trace_buffer #(.DEPTH(16), .SEQ_W(16), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .flush(flush),
        .clear_ovf(clear_ovf), .retire_valid(retire_valid),
        .retire_pc(retire_pc), .retire_instr(retire_instr),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_instr(out_instr),
        .out_rd(out_rd), .out_rdata(out_rdata), .out_write_op(out_write_op),
        .out_wdata(out_wdata), .out_waddr(out_waddr), .count(count),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] seq_m  = '0;
    logic        ovf_m  = 1'b0;
    logic [7:0]  drop_m = '0;
    int          n_checks = 0;
    int          n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected record built from the retire inputs as currently driven.
    function automatic exp_t make_exp(input logic [15:0] s);
        exp_t e;
        e.seq   = s;
        e.pc    = retire_pc;
        e.instr = retire_instr;
        e.rd    = (rd_we && rd_addr != 5'd0) ? rd_addr : 5'd0;
        e.rdata = (rd_we && rd_addr != 5'd0) ? rd_wdata : 32'd0;
        e.op    = 2'd0;
        e.wdata = 32'd0;
        e.waddr = 32'd0;
        if (mem_we && mem_size != 2'd3) begin
            e.op    = mem_size + 2'd1;
            e.waddr = mem_addr;
            case (mem_size)
                2'd0:    e.wdata = mem_wdata & 32'h0000_00FF;
                2'd1:    e.wdata = mem_wdata & 32'h0000_FFFF;
                default: e.wdata = mem_wdata;
            endcase
        end
        return e;
    endfunction

    // Compare DUT against the reference, then advance the reference for the coming edge.
    task automatic model_step();
        exp_t h;
        bit   full, pop, push, drop;
        check("out_valid", out_valid, sb.size() != 0);
        check("count", count, sb.size());
        check("ovf", ovf, ovf_m);
        check("drop_cnt", drop_cnt, drop_m);
        if (sb.size() != 0) begin
            h = sb[0];
            check("seq", out_seq, h.seq);
            check("pc", out_pc, h.pc);
            check("instr", out_instr, h.instr);
            check("rd", out_rd, h.rd);
            check("rdata", out_rdata, h.rdata);
            check("write_op", out_write_op, h.op);
            check("wdata", out_wdata, h.wdata);
            check("waddr", out_waddr, h.waddr);
        end
        drop = 1'b0;
        if (flush) begin
            sb.delete();
        end else begin
            full = (sb.size() == DEPTH);
            pop  = (sb.size() != 0) && out_ready;
            push = retire_valid && trace_en;
            if (pop) void'(sb.pop_front());
            if (push) begin
                if (full && !pop) drop = 1'b1;
                else sb.push_back(make_exp(seq_m));
            end
        end
        if (clear_ovf) begin
            ovf_m  = drop;
            drop_m = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf_m = 1'b1;
            if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
        end
        if (retire_valid) seq_m = seq_m + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                          input logic rwe, input logic [4:0] ra, input logic [31:0] rdat,
                          input logic mwe, input logic [1:0] msz,
                          input logic [31:0] maddr, input logic [31:0] mdat);
        retire_pc = pc; retire_instr = instr;
        rd_we = rwe; rd_addr = ra; rd_wdata = rdat;
        mem_we = mwe; mem_size = msz; mem_addr = maddr; mem_wdata = mdat;
        retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic alu_retire(input logic [31:0] pc);
        retire(pc, ADDI_X5, 1'b1, 5'd5, 32'h11, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drain with a bounded wait.
    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) tick();
        check("drain_done", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trace_en = 1'b1; flush = 1'b0; clear_ovf = 1'b0;
        retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
        rd_we = 1'b0; rd_addr = '0; rd_wdata = '0;
        mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        out_ready = 1'b0;

        fork
            forever begin
                @(negedge clk or posedge rst);
                if (rst) begin
                    sb.delete();
                    seq_m = '0; ovf_m = 1'b0; drop_m = '0;
                end else begin
                    model_step();
                end
            end
        join_none

        // Reset state
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_pc", out_pc, 0);
        check("rst_seq", out_seq, 0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_drop", drop_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        // Three ALU retires, consumer always ready
        out_ready = 1'b1;
        alu_retire(32'h0);
        check("s1_valid", out_valid, 1'b1);
        check("s1_seq0", out_seq, 16'd0);
        check("s1_rd", out_rd, 5'd5);
        check("s1_rdata", out_rdata, 32'h11);
        alu_retire(32'h4);
        check("s1_seq1", out_seq, 16'd1);
        alu_retire(32'h8);
        check("s1_seq2", out_seq, 16'd2);
        tick();
        check("s1_empty", out_valid, 1'b0);

        // Store byte / half / word / reserved
        retire(32'hC, 32'h0020_81A3, 1'b0, 5'd0, 32'd0, 1'b1, 2'd0, 32'h1003, 32'hAABB_CCDD);
        check("sb_op", out_write_op, 2'd1);
        check("sb_wdata", out_wdata, 32'hDD);
        check("sb_waddr", out_waddr, 32'h1003);
        retire(32'h10, 32'h0020_91A3, 1'b0, 5'd0, 32'd0, 1'b1, 2'd1, 32'h1003, 32'hAABB_CCDD);
        check("sh_wdata", out_wdata, 32'hCCDD);
        retire(32'h14, 32'h0020_A1A3, 1'b0, 5'd0, 32'd0, 1'b1, 2'd2, 32'h1003, 32'hAABB_CCDD);
        check("sw_op", out_write_op, 2'd3);
        check("sw_wdata", out_wdata, 32'hAABB_CCDD);
        retire(32'h18, 32'h0020_B1A3, 1'b0, 5'd0, 32'd0, 1'b1, 2'd3, 32'h1003, 32'hAABB_CCDD);
        check("rsv_op", out_write_op, 2'd0);
        check("rsv_waddr", out_waddr, 32'd0);

        // Write to x0 is suppressed
        retire(32'h1C, 32'h0050_0013, 1'b1, 5'd0, 32'h5, 1'b0, 2'd0, 32'd0, 32'd0);
        check("x0_rd", out_rd, 5'd0);
        check("x0_rdata", out_rdata, 32'd0);
        tick();

        // Overflow: DEPTH+3 retires with no consumer
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 19; i++) alu_retire(32'(i * 4));
        check("ov_count", count, 16);
        check("ov_ovf", ovf, 1'b1);
        check("ov_drop", drop_cnt, 3);
        check("ov_head", out_seq, 16'd0);
        out_ready = 1'b1;
        repeat (16) tick();
        out_ready = 1'b0;
        alu_retire(32'h100);
        check("gap_seq", out_seq, 16'd19);
        check("gap_count", count, 1);

        // Full with simultaneous pop, then clear_ovf racing a drop
        for (int i = 0; i < 15; i++) alu_retire(32'(32'h200 + i * 4));
        check("full_count", count, 16);
        out_ready = 1'b1;
        alu_retire(32'h300);
        out_ready = 1'b0;
        check("fp_count", count, 16);
        check("fp_drop", drop_cnt, 3);
        check("fp_ovf", ovf, 1'b1);
        clear_ovf = 1'b1;
        alu_retire(32'h304);
        clear_ovf = 1'b0;
        check("clr_race_ovf", ovf, 1'b1);
        check("clr_race_drop", drop_cnt, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clr_ovf", ovf, 1'b0);
        check("clr_drop", drop_cnt, 0);
        drain();

        // trace_en gating: seq advances past uncaptured retires
        trace_en = 1'b0;
        alu_retire(32'h400);
        alu_retire(32'h404);
        trace_en = 1'b1;
        check("en_none", out_valid, 1'b0);
        alu_retire(32'h408);
        check("en_seq", out_seq, 16'd39);
        drain();

        // Flush with 5 entries queued
        for (int i = 0; i < 5; i++) alu_retire(32'(32'h500 + i * 4));
        check("fl_pre", count, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_count", count, 0);
        check("fl_valid", out_valid, 1'b0);
        alu_retire(32'h600);
        check("fl_seq", out_seq, 16'd45);
        drain();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            retire_valid = ($urandom_range(0, 3) != 0);
            trace_en     = ($urandom_range(0, 7) != 0);
            out_ready    = ($urandom_range(0, 1) != 0);
            flush        = ($urandom_range(0, 31) == 0);
            clear_ovf    = ($urandom_range(0, 15) == 0);
            retire_pc    = $urandom;
            retire_instr = $urandom;
            rd_we        = ($urandom_range(0, 1) != 0);
            rd_addr      = 5'($urandom);
            rd_wdata     = $urandom;
            mem_we       = ($urandom_range(0, 1) != 0);
            mem_size     = 2'($urandom);
            mem_addr     = $urandom;
            mem_wdata    = $urandom;
            tick();
        end
        retire_valid = 1'b0; flush = 1'b0; clear_ovf = 1'b0; trace_en = 1'b1;
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) alu_retire(32'(32'h700 + i * 4));
        check("ar_pre", count, 3);
        rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_count", count, 0);
        check("ar_pc", out_pc, 0);
        rst = 1'b0;
        tick();
        alu_retire(32'h800);
        check("ar_seq", out_seq, 16'd0);
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Sits between the RISC-V core's retire/writeback stage and the UVM trace monitor.
- Captures one record per retired instruction: PC, instruction word, register write, memory write.
- Buffers the records in a FIFO and presents them on a valid/ready stream, so the scoreboard can step the instruction-set simulator once per record and compare rd / write-op / write-data / write-address.
- Tags records with a sequence number so that dropped records are detectable.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- SEQ_W, 16, width of the retire sequence number; wraps modulo 2^SEQ_W.
- DROP_W, 8, width of the dropped-record counter; saturating.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- trace_en  in  1  capture enable.
- flush  in  1  synchronous FIFO clear.
- clear_ovf  in  1  synchronous clear of ovf and drop_cnt.
- retire_valid  in  1  one instruction retires this cycle.
- retire_pc  in  32  PC of the retiring instruction.
- retire_instr  in  32  instruction word.
- rd_we  in  1  register write occurs.
- rd_addr  in  5  destination register.
- rd_wdata  in  32  register write data.
- mem_we  in  1  store occurs.
- mem_size  in  2  store size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- mem_addr  in  32  store byte address.
- mem_wdata  in  32  store data, LSB-aligned.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_seq  out  SEQ_W  sequence number.
- out_pc  out  32  PC.
- out_instr  out  32  instruction word.
- out_rd  out  5  register written; 0 means none.
- out_rdata  out  32  register write data; 0 if out_rd = 0.
- out_write_op  out  2  0 = none, 1 = byte, 2 = half, 3 = word.
- out_wdata  out  32  store data, masked to size.
- out_waddr  out  32  store address; 0 if no store.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky: a record was dropped.
- drop_cnt  out  DROP_W  number of dropped records, saturating.

Behaviour:
- Reset: all FIFO storage, pointers, count, seq counter, ovf and drop_cnt go to 0. Consequently out_valid = 0 and every out_* field = 0.
- Sequence counter:
  - Increments on every cycle with retire_valid = 1, regardless of trace_en, full or flush.
  - A record captured this cycle takes the pre-increment value. The first retire after reset has seq = 0.
  - Wraps from 2^SEQ_W-1 to 0.
- Push condition: retire_valid & trace_en & !flush.
- Record formation (combinational, at push):
  - rd_we = 1 and rd_addr != 0 → out_rd = rd_addr, out_rdata = rd_wdata.
  - Otherwise out_rd = 0 and out_rdata = 0. Writes to x0 are suppressed.
  - mem_we = 1 and mem_size in 0..2 → write_op = mem_size+1; waddr = mem_addr, passed unmodified even if misaligned.
  - wdata masking: byte → {24'b0, mem_wdata[7:0]}; half → {16'b0, mem_wdata[15:0]}; word → full value.
  - mem_we = 0 or mem_size = 3 → write_op = 0, wdata = 0, waddr = 0.
- FIFO:
  - Registered storage; the out_* fields are the head entry.
  - Latency: a record pushed at edge N is visible with out_valid = 1 after edge N if the FIFO was empty.
  - A pop occurs on an edge where out_valid & out_ready.
  - out_ready with out_valid = 0 has no effect.
  - Pointers wrap modulo DEPTH.
  - count = occupancy, range 0..DEPTH.
- Full handling:
  - Push while count = DEPTH and no pop that cycle → record dropped, ovf set, drop_cnt += 1, saturating at 2^DROP_W-1.
  - Push while full and popping in the same cycle → accepted; count stays DEPTH.
- Simultaneous push and pop when count is 1..DEPTH-1 → count unchanged; order preserved.
- When empty, a push and an out_ready in the same cycle → no pop. The record appears on the next cycle.
- flush:
  - Sets pointers and count to 0 on the next edge; the pending push and pop are ignored.
  - ovf, drop_cnt and the seq counter are unaffected.
  - Storage contents are not cleared. While empty, out fields show stale data with out_valid = 0.
- clear_ovf: clears ovf and drop_cnt on the next edge. If a drop occurs in the same cycle, the drop wins: ovf = 1, drop_cnt = 1.
- Asynchronous reset mid-stream: all state, including in-flight records, is discarded immediately and out_valid drops without waiting for a clock edge.

Test Plan:
- Reset, then 3 retires with out_ready = 1: PC 0x0,0x4,0x8; ADDI x5, rd_wdata = 0x11 → 3 records with seq 0,1,2, out_rd = 5, out_rdata = 0x11, write_op = 0, each arriving 1 cycle after capture.
- Store-byte mem_addr = 0x1003, mem_wdata = 0xAABBCCDD, followed by store-half and store-word → write_op 1/2/3; wdata 0xDD / 0xCCDD / 0xAABBCCDD; waddr 0x1003 unchanged.
- Write to x0 with rd_wdata = 0x5 → out_rd = 0, out_rdata = 0.
- out_ready = 0 with DEPTH+3 = 19 retires → count = 16, ovf = 1, drop_cnt = 3. Draining shows seq 0..15; the next capture has seq 19, exposing the gap.
- Full FIFO, retire plus out_ready in the same cycle → count stays 16, no drop, ovf unchanged. Then clear_ovf coinciding with a drop → ovf = 1, drop_cnt = 1.
- trace_en = 0 for 2 retires, then re-enable → no records for those retires; the next record has seq advanced by 2. Assert flush with 5 entries queued → count = 0 and out_valid = 0 next cycle; seq continues.
